seg7: RTL and testbench

SEG7 -- requirements
Module: seg7

---
 rtl/seg7.sv | 87 ++++++++
 tb/tb_seg7.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7.sv
// seg7 - hexadecimal / BCD to seven-segment decoder.
//
// Decodes a 4-bit code into a seven-segment drive pattern. Segment polarity,
// output registering and blanking of codes 10-15 are set by parameters.
//
// Parameters:
//   ACTIVE_LOW    1: lit segment drives 0; 0: lit segment drives 1
//   REGISTERED    1: output taken from a flop stage; 0: purely combinational
//   BLANK_INVALID 1: codes 10-15 blank the display; 0: show hex glyphs A-F
//
// Ports:
//   clk     in   1  system clock, rising-edge active
//   reset   in   1  asynchronous reset, active low
//   bcd     in   4  value to display, 0-15
//   inverse out  7  segment drive, bit0=a .. bit6=g
module seg7 #(
   parameter bit ACTIVE_LOW    = 1'b1,
   parameter bit REGISTERED    = 1'b1,
   parameter bit BLANK_INVALID = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] bcd,
   output logic [6:0] inverse
);

   // All-segments-off level for the selected polarity.
   localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;

   // Glyph table held in active-low form (gfedcba, 0 = lit).
   logic [6:0] pattern_al;
   logic [6:0] decoded;

   always_comb begin
      pattern_al = 7'h7F;
      unique case (bcd)
         4'h0: pattern_al = 7'h40;
         4'h1: pattern_al = 7'h79;
         4'h2: pattern_al = 7'h24;
         4'h3: pattern_al = 7'h30;
         4'h4: pattern_al = 7'h19;
         4'h5: pattern_al = 7'h12;
         4'h6: pattern_al = 7'h02;
         4'h7: pattern_al = 7'h78;
         4'h8: pattern_al = 7'h00;
         4'h9: pattern_al = 7'h10;
         4'hA: pattern_al = BLANK_INVALID ? 7'h7F : 7'h08;
         4'hB: pattern_al = BLANK_INVALID ? 7'h7F : 7'h03;
         4'hC: pattern_al = BLANK_INVALID ? 7'h7F : 7'h46;
         4'hD: pattern_al = BLANK_INVALID ? 7'h7F : 7'h21;
         4'hE: pattern_al = BLANK_INVALID ? 7'h7F : 7'h06;
         4'hF: pattern_al = BLANK_INVALID ? 7'h7F : 7'h0E;
         default: pattern_al = 7'h7F;
      endcase
   end

   always_comb begin
      decoded = ACTIVE_LOW ? pattern_al : ~pattern_al;
   end

   generate
      if (REGISTERED) begin : g_reg
         logic [6:0] seg_q;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               seg_q <= BLANK;
            end else begin
               seg_q <= decoded;
            end
         end

         always_comb begin
            inverse = seg_q;
         end
      end else begin : g_comb
         // Clock and reset play no part in the combinational variant.
         logic unused_clk_reset;

         always_comb begin
            unused_clk_reset = clk ^ reset;
            inverse          = decoded;
         end
      end
   endgenerate

endmodule

// File: tb/tb_seg7.sv
// tb_seg7 - scoreboard bench for seg7.
//
// Three registered instances (default, BLANK_INVALID=1, ACTIVE_LOW=0) share
// clk/reset/bcd; a fourth combinational instance has its own bcd with its
// clock stopped and its reset held asserted. Expected patterns come from
// glyph descriptions written as strings of lit segment letters.
module tb_seg7;

   logic       clk     = 1'b0;
   logic       reset   = 1'b0;
   logic [3:0] bcd     = 4'h0;
   logic       clk_c   = 1'b0;
   logic       reset_c = 1'b0;
   logic [3:0] bcd_c   = 4'h0;

   logic [6:0] out_def;
   logic [6:0] out_blk;
   logic [6:0] out_ah;
   logic [6:0] out_comb;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         code;
      logic [6:0] e_def;
      logic [6:0] e_blk;
      logic [6:0] e_ah;
   } exp_t;

   exp_t sb[$];

   // Lit segments of each glyph, by segment letter.
   string glyph [16] = '{
      "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
      "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"
   };

   always #5 clk = ~clk;

   seg7 #(.ACTIVE_LOW(1'b1), .REGISTERED(1'b1), .BLANK_INVALID(1'b0)) u_def (
      .clk(clk), .reset(reset), .bcd(bcd), .inverse(out_def));

   seg7 #(.ACTIVE_LOW(1'b1), .REGISTERED(1'b1), .BLANK_INVALID(1'b1)) u_blk (
      .clk(clk), .reset(reset), .bcd(bcd), .inverse(out_blk));

   seg7 #(.ACTIVE_LOW(1'b0), .REGISTERED(1'b1), .BLANK_INVALID(1'b0)) u_ah (
      .clk(clk), .reset(reset), .bcd(bcd), .inverse(out_ah));

   seg7 #(.ACTIVE_LOW(1'b1), .REGISTERED(1'b0), .BLANK_INVALID(1'b0)) u_comb (
      .clk(clk_c), .reset(reset_c), .bcd(bcd_c), .inverse(out_comb));

   function automatic logic [6:0] model(int v, bit al, bit blank);
      logic [6:0] lit;
      int         idx;
      lit = '0;
      if (!(blank && v >= 10)) begin
         for (int i = 0; i < glyph[v].len(); i++) begin
            idx = int'(glyph[v].getc(i)) - 97;
            lit[idx] = 1'b1;
         end
      end
      return al ? ~lit : lit;
   endfunction

   task automatic check(string name, logic [6:0] act, logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a falling edge: the pattern must appear after the next rising edge.
   task automatic drive(int v);
      exp_t e;
      bcd     = v[3:0];
      e.code  = v;
      e.e_def = model(v, 1'b1, 1'b0);
      e.e_blk = model(v, 1'b1, 1'b1);
      e.e_ah  = model(v, 1'b0, 1'b0);
      sb.push_back(e);
   endtask

   task automatic check_blank(string name);
      check({name, "_def"}, out_def, 7'h7F);
      check({name, "_blk"}, out_blk, 7'h7F);
      check({name, "_ah"},  out_ah,  7'h00);
   endtask

   // Monitor: each rising edge consumes the oldest outstanding expectation.
   exp_t m;
   always @(posedge clk) begin
      #2;
      if (sb.size() > 0) begin
         m = sb.pop_front();
         check($sformatf("sb_def_code%0d", m.code), out_def, m.e_def);
         check($sformatf("sb_blk_code%0d", m.code), out_blk, m.e_blk);
         check($sformatf("sb_ah_code%0d",  m.code), out_ah,  m.e_ah);
      end
   end

   task automatic drain;
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain actual=%0d expected=0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      // Held in reset with bcd=3 and the clock running.
      reset = 1'b0;
      bcd   = 4'h3;
      repeat (4) begin
         @(negedge clk);
         check_blank("in_reset");
         @(posedge clk);
         #1;
         check_blank("in_reset_edge");
      end

      // Release: still blank until the first rising edge, then the decode of 3.
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_blank("post_release_pre_edge");
      drive(3);
      @(posedge clk);
      #3;
      check("release_3", out_def, 7'h30);

      // Sweep 0..15, one value per cycle.
      for (int v = 0; v < 16; v++) begin
         @(negedge clk);
         drive(v);
      end

      // Directed BLANK_INVALID and polarity points.
      foreach (glyph[i]) begin end
      @(negedge clk); drive(12);
      @(negedge clk); drive(9);
      @(negedge clk); drive(8);
      @(negedge clk); drive(1);

      // Stable value held for several cycles.
      repeat (6) begin
         @(negedge clk);
         drive(7);
      end

      // Random stream.
      repeat (200) begin
         @(negedge clk);
         drive(int'($urandom_range(15)));
      end

      drain();

      // Reset asserted between edges while showing 2.
      @(negedge clk);
      drive(2);
      @(posedge clk);
      #3;
      check("pre_reset_2", out_def, 7'h24);
      reset = 1'b0;
      #1;
      check_blank("mid_reset");
      repeat (3) begin
         @(posedge clk);
         #1;
         check_blank("mid_reset_hold");
      end
      @(negedge clk);
      reset = 1'b1;
      drive(2);
      @(negedge clk);
      drive(15);
      drain();

      // Combinational instance: clock stopped, its reset held low.
      foreach (bcd_c[i]) begin end
      for (int k = 3; k >= 0; k--) begin
         bcd_c = k[3:0];
         #1;
         check($sformatf("comb_code%0d", k), out_comb, model(k, 1'b1, 1'b0));
      end
      check("comb_0_literal", out_comb, 7'h40);
      repeat (50) begin
         int v;
         v = int'($urandom_range(15));
         bcd_c = v[3:0];
         #1;
         check($sformatf("comb_rand_code%0d", v), out_comb, model(v, 1'b1, 1'b0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
